// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit, price/stock-checked selection,
// dispense handshake with timeout refund, and coin-by-coin change payout.
//
// Handshakes: dispense_req/dispense_id and change_req/change_val are registered and
// held until the matching *_ack is sampled high on a rising edge; acks outside
// their handshake are ignored.
module vend_ctrl_multi #(
    parameter int                   N_PROD     = 4,
    parameter int                   CW         = 6,
    parameter logic [N_PROD*CW-1:0] PRICES     = {6'd5, 6'd4, 6'd3, 6'd3},
    parameter logic [4*CW-1:0]      COIN_VALS  = {6'd10, 6'd5, 6'd2, 6'd1},
    parameter int                   MAX_CREDIT = 30,
    parameter int                   TIMEOUT    = 255,
    localparam int                  IDW        = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coin_valid,
    input  logic [1:0]        coin_sel,
    input  logic              sel_valid,
    input  logic [IDW-1:0]    sel_id,
    input  logic              cancel,
    input  logic [N_PROD-1:0] stock_empty,
    output logic              dispense_req,
    output logic [IDW-1:0]    dispense_id,
    input  logic              dispense_ack,
    output logic              change_req,
    output logic [1:0]        change_val,
    input  logic              change_ack,
    output logic [CW-1:0]     credit,
    output logic              coin_reject,
    output logic              sel_nack,
    output logic              fault,
    output logic [1:0]        dbg_state_o
);

    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW:0]   MAX_C      = (CW + 1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    credit_q, credit_d;
    logic [CW-1:0]    chg_q, chg_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             fault_q, fault_d;
    logic             coin_rej_q, coin_rej_d;
    logic             nack_q, nack_d;
    logic             disp_req_q;
    logic             chg_req_q;
    logic [1:0]       chg_val_q;

    logic [CW-1:0]    coin_val;
    logic [CW:0]      coin_sum;
    logic [CW-1:0]    sel_price;
    logic             sel_stock_empty;
    logic             sel_in_range;
    logic             sel_ok;
    logic [CW-1:0]    vend_price;

    // Table lookups; out-of-range selections fall through with sel_in_range low.
    always_comb begin
        coin_val        = '0;
        sel_price       = '0;
        sel_stock_empty = 1'b0;
        sel_in_range    = 1'b0;
        vend_price      = '0;
        for (int i = 0; i < 4; i++) begin
            if (coin_sel == 2'(i)) coin_val = COIN_VALS[i*CW +: CW];
        end
        for (int i = 0; i < N_PROD; i++) begin
            if (sel_id == IDW'(i)) begin
                sel_in_range    = 1'b1;
                sel_price       = PRICES[i*CW +: CW];
                sel_stock_empty = stock_empty[i];
            end
            if (id_q == IDW'(i)) vend_price = PRICES[i*CW +: CW];
        end
    end

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    assign sel_ok   = sel_in_range && !sel_stock_empty && (credit_q >= sel_price);

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        chg_d      = chg_q;
        timer_d    = timer_q;
        id_d       = id_q;
        fault_d    = fault_q;
        coin_rej_d = 1'b0;
        nack_d     = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (cancel) begin
                    coin_rej_d = coin_valid;
                    if (credit_q != '0) begin
                        chg_d    = credit_q;
                        credit_d = '0;
                        state_d  = CHANGE;
                    end
                end else if (sel_valid) begin
                    coin_rej_d = coin_valid;
                    if (!sel_ok) begin
                        nack_d = 1'b1;
                    end else begin
                        id_d     = sel_id;
                        chg_d    = credit_q - sel_price;
                        credit_d = '0;
                        state_d  = VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_sum > MAX_C) coin_rej_d = 1'b1;
                    else                  credit_d   = coin_sum[CW-1:0];
                end
            end
            VEND: begin
                coin_rej_d = coin_valid;
                nack_d     = sel_valid;
                if (dispense_ack) begin
                    timer_d = '0;
                    state_d = (chg_q != '0) ? CHANGE : IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    // No ack in time: refund the price on top of any change owed.
                    timer_d = '0;
                    fault_d = 1'b1;
                    chg_d   = chg_q + vend_price;
                    state_d = CHANGE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHANGE: begin
                coin_rej_d = coin_valid;
                nack_d     = sel_valid;
                if (change_ack) begin
                    chg_d = chg_q - {{(CW-2){1'b0}}, chg_val_q};
                    if (chg_d == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            chg_q      <= '0;
            timer_q    <= '0;
            id_q       <= '0;
            fault_q    <= 1'b0;
            coin_rej_q <= 1'b0;
            nack_q     <= 1'b0;
            disp_req_q <= 1'b0;
            chg_req_q  <= 1'b0;
            chg_val_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            chg_q      <= chg_d;
            timer_q    <= timer_d;
            id_q       <= id_d;
            fault_q    <= fault_d;
            coin_rej_q <= coin_rej_d;
            nack_q     <= nack_d;
            // Handshake outputs are registered from the next state so they line up with it.
            disp_req_q <= (state_d == VEND);
            chg_req_q  <= (state_d == CHANGE);
            if (state_d == CHANGE) chg_val_q <= (chg_d >= CW'(2)) ? 2'd2 : 2'd1;
            else                   chg_val_q <= 2'd0;
        end
    end

    assign dispense_req = disp_req_q;
    assign dispense_id  = id_q;
    assign change_req   = chg_req_q;
    assign change_val   = chg_val_q;
    assign credit       = credit_q;
    assign coin_reject  = coin_rej_q;
    assign sel_nack     = nack_q;
    assign fault        = fault_q;
    assign dbg_state_o  = state_q;

endmodule
